// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: debounced set/reset buttons to mutually exclusive fixed-width S/R pulses
module sr_pulse_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int PULSE_LEN  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  output logic S,
  output logic R,
  output logic conflict,
  output logic busy,
  output logic set_level,
  output logic rst_level
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PL_MAX = PW'(PULSE_LEN - 1);
  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;
  state_t state_q, state_d;
  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, level_q, level_d, lvl_dly_q, lvl_dly_d, req;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic pend_v_q, pend_v_d, pend_r_q, pend_r_d;
  logic s_q, s_d, r_q, r_d, conflict_q, conflict_d;
  logic set_req, rst_req;
  always_comb begin
    sync1_d = {rst_btn, set_btn};
    sync2_d = sync1_q;
    lvl_dly_d = level_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (sync2_q[i] == level_q[i] || cnt_q[i] == DEB_MAX) ? '0 : cnt_q[i] + 1'b1;
      level_d[i] = level_q[i] ^ (sync2_q[i] != level_q[i] && cnt_q[i] == DEB_MAX);
    end
    req = level_q & ~lvl_dly_q;
    set_req = req[0];
    rst_req = req[1];
  end
  always_comb begin
    state_d = state_q;
    pcnt_d = pcnt_q;
    pend_v_d = pend_v_q;
    pend_r_d = pend_r_q;
    conflict_d = set_req && rst_req;
    case (state_q)
      IDLE: begin
        if (set_req ^ rst_req) begin
          state_d = set_req ? PULSE_S : PULSE_R;
          pcnt_d = '0;
        end else if (!rst_req && pend_v_q) begin
          state_d = pend_r_q ? PULSE_R : PULSE_S;
          pend_v_d = 1'b0;
          pcnt_d = '0;
        end
      end
      PULSE_S, PULSE_R: begin
        state_d = (pcnt_q == PL_MAX) ? GAP : state_q;
        pcnt_d = pcnt_q + 1'b1;
      end
      default: begin
        state_d = pend_v_q ? (pend_r_q ? PULSE_R : PULSE_S) : IDLE;
        pend_v_d = 1'b0;
        pcnt_d = '0;
      end
    endcase
    // a request landing while busy overwrites the slot after any GAP consume
    if (set_req && rst_req) pend_v_d = 1'b0;
    else if (state_q != IDLE && (set_req || rst_req)) begin
      pend_v_d = 1'b1;
      pend_r_d = rst_req;
    end
    s_d = state_d == PULSE_S;
    r_d = state_d == PULSE_R;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      lvl_dly_q <= '0;
      cnt_q <= '{default: '0};
      state_q <= IDLE;
      pcnt_q <= '0;
      pend_v_q <= 1'b0;
      pend_r_q <= 1'b0;
      s_q <= 1'b0;
      r_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      lvl_dly_q <= lvl_dly_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      pcnt_q <= pcnt_d;
      pend_v_q <= pend_v_d;
      pend_r_q <= pend_r_d;
      s_q <= s_d;
      r_q <= r_d;
      conflict_q <= conflict_d;
    end
  end
  assign S = s_q;
  assign R = r_q;
  assign conflict = conflict_q;
  assign busy = state_q != IDLE;
  assign set_level = level_q[0];
  assign rst_level = level_q[1];
  assert property (@(posedge clk) disable iff (!rst_n) !(s_q && r_q));
endmodule

// File: doc/sr_pulse_gen.md
Name: sr_pulse_gen

Overview:
- Front-end stage that sits directly upstream of the SR latch and drives its S and R inputs.
- Takes two raw, bouncy push-button inputs (set and reset) and synchronises and debounces each one.
- Converts each debounced rising edge into a clean, fixed-width, registered pulse on S or R.
- Guarantees S and R are never asserted together, so the latch's forbidden S=R=1 state can never be produced from this side.

Parameters:
- DEB_CYCLES, default 4: consecutive stable synchronised cycles required before a debounced level changes. Legal range ≥2.
- PULSE_LEN, default 2: width of each S/R output pulse, in clk cycles. Legal range ≥1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- set_btn  input  1  raw asynchronous set button
- rst_btn  input  1  raw asynchronous reset button
- S  output  1  registered set pulse to the SR latch
- R  output  1  registered reset pulse to the SR latch
- conflict  output  1  one-cycle flag: set and reset requests collided and both were discarded
- busy  output  1  high whenever the FSM is not in IDLE
- set_level  output  1  debounced set level
- rst_level  output  1  debounced reset level

Behaviour:
- Clock and reset (already decided):
  - One clock, clk.
  - rst_n is asynchronous and active-low. Assertion immediately clears every flop:
    - synchronisers, debounce counters, levels, edge-delay flops
    - pending slot; FSM returns to IDLE
    - S=R=conflict=busy=set_level=rst_level=0
  - Reset mid-pulse truncates the pulse at once. No pulse is resumed after reset.
- Synchroniser:
  - Each raw input passes through 2 flops.
  - Edge 1 samples the raw input into stage 1; stage 2 updates on edge 2.
- Debounce, per channel:
  - If the synced value equals the level, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals DEB_CYCLES-1 and a mismatch still exists: the level flips and the counter clears.
  - A mismatch lasting fewer than DEB_CYCLES cycles produces no level change.
  - Level rises on edge DEB_CYCLES+2 after the raw input is first sampled.
- Edge detect:
  - req = level & ~level_d (combinational).
  - Falling edges are ignored.
  - A button held through reset release yields a request once debounced, because levels reset to 0.
- FSM states: IDLE, PULSE_S, PULSE_R, GAP.
  - IDLE:
    - set_req & rst_req → assert conflict for one cycle, stay in IDLE.
    - set_req only → PULSE_S.
    - rst_req only → PULSE_R.
  - PULSE_S / PULSE_R:
    - S (or R) is high from the entry edge for exactly PULSE_LEN cycles, then → GAP.
  - GAP:
    - Exactly one cycle with S=R=0.
    - If pending is valid → the matching PULSE state, and pending clears.
    - Otherwise → IDLE.
  - New requests while not in IDLE:
    - Stored in a single-entry pending slot (type: set or reset).
    - A later request overwrites the slot.
    - Simultaneous set_req & rst_req outside IDLE: assert conflict and clear pending.
  - A request arriving in the same cycle GAP consumes pending: the new request is written to pending after the consume. New request wins and is held for the next GAP.
- Outputs:
  - S, R, conflict are registered.
  - S & R == 0 at all times (assertion-checked).
  - busy = (state != IDLE).
- Latency: an isolated clean press produces S/R rising on edge DEB_CYCLES+3 after first sample.

Test Plan:
All scenarios use DEB_CYCLES=4 and PULSE_LEN=2.
- Reset check: hold rst_n=0 with buttons toggling → every output is 0. Release → outputs stay 0 while buttons are low.
- Clean set press: set_btn goes 0→1 and is held → set_level rises at edge 6; S=1 on edges 7–8 and 0 from edge 9; R never asserts; conflict=0; busy on edges 7–9.
- Bounce rejection: set_btn high for 3 cycles, low for 2, then high and held → no S for the short burst; exactly one S pulse, 2 cycles wide, DEB_CYCLES+3 edges after the final rise.
- Collision: set_btn and rst_btn rise on the same cycle and are held → conflict=1 for one cycle at edge 7; S=R=0 throughout; FSM stays in IDLE.
- Queued pair: rst_btn rises, set_btn rises one cycle later → R=1 on edges 7–8, GAP at edge 9, S=1 on edges 10–11, then IDLE. S&R never both high.
- Reset mid-pulse: pull rst_n low while S=1 → S=0 immediately, without a clock edge. Keep set_btn held and release reset → fresh S pulse on edges DEB_CYCLES+3 to DEB_CYCLES+4 after release.
